// File: rtl/subservient_loader_pkg.sv
// Purpose: shared types and constants for the subservient UART firmware loader.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package subservient_loader_pkg;

  // Loader sequencing: length header, payload packing, bus write, optional checksum, terminal states
  typedef enum logic [2:0] {
    ST_LEN,
    ST_DATA,
    ST_WRITE,
    ST_CKSUM,
    ST_DONE,
    ST_ERROR
  } state_t;

  // The debug port is only ever written with full words
  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  // Byte counter must reach MEMSIZE itself, hence one bit more than the address width
  function automatic int byte_cnt_width(input int memsize);
    return $clog2(memsize) + 1;
  endfunction

endpackage

// File: rtl/subservient_uart_rx.sv
// Purpose: 8N1 UART receiver with 2-flop input synchronizer and false-start rejection.
// Latency: o_valid/o_frame_err pulse one cycle, about 9.5 bit times after the start edge.
// Backpressure: none; each byte is presented for one cycle and the consumer must keep up.
module subservient_uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;

  rx_state_t     st, st_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          valid_nxt, ferr_nxt;

  // Line synchronizer plus one delayed copy for falling-edge detection; idle line is high
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit timing: start bit re-checked at half a bit, data and stop sampled at bit centres
  always_comb begin
    st_nxt      = st;
    cnt_nxt     = cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
    case (st)
      RX_IDLE: begin
        cnt_nxt = '0;
        if (rx_prev && !rx_sync) st_nxt = RX_START;
      end
      RX_START: begin
        if (cnt == CNT_HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = 3'd0;
          st_nxt      = rx_sync ? RX_IDLE : RX_BITS;
        end
      end
      RX_BITS: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt     = '0;
          shreg_nxt   = {rx_sync, shreg[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) st_nxt = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_nxt   = '0;
          st_nxt    = RX_IDLE;
          valid_nxt = rx_sync;
          ferr_nxt  = !rx_sync;
        end
      end
      default: st_nxt = RX_IDLE;
    endcase
  end

  // Receiver state and one-cycle result pulses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st          <= RX_IDLE;
      cnt         <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'd0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      st          <= st_nxt;
      cnt         <= cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shreg       <= shreg_nxt;
      o_valid     <= valid_nxt;
      o_frame_err <= ferr_nxt;
    end
  end

  assign o_data = shreg;

endmodule

// File: rtl/subservient_uart_loader.sv
// Purpose: UART firmware loader; writes a length-prefixed image into SRAM over the debug
//   Wishbone port, then releases debug mode. SUBSERVIENT_LOADER_CHECKSUM_EN adds a sum byte.
// Latency: write strobe rises 2 cycles after a word completes; stb held until ack.
// Backpressure: one-byte buffer; a new UART byte arriving while it is still full is an error.
module subservient_uart_loader
  import subservient_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int MEMSIZE      = 8192
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  output logic        o_debug_mode,
  output logic [31:0] o_wb_dbg_adr,
  output logic [31:0] o_wb_dbg_dat,
  output logic [3:0]  o_wb_dbg_sel,
  output logic        o_wb_dbg_we,
  output logic        o_wb_dbg_stb,
  input  logic        i_wb_dbg_ack,
  output logic        o_done,
  output logic        o_error
);

  localparam int          W       = byte_cnt_width(MEMSIZE);
  localparam logic [31:0] MEM_LIM = 32'(MEMSIZE);

`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
  localparam state_t ST_TAIL = ST_CKSUM;
`else
  localparam state_t ST_TAIL = ST_DONE;
`endif

  logic [7:0]   rx_data;
  logic         rx_valid, rx_ferr;

  state_t       state, state_nxt;
  logic [7:0]   byte_buf;
  logic         byte_pend, consume;
  logic [31:0]  len_sr, len_full;
  logic [1:0]   len_idx;
  logic [W-1:0] len_n, byte_cnt, word_idx;
  logic         last_byte;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
  logic [7:0]   sum;
`endif

  subservient_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_rx        (i_rx),
    .o_data      (rx_data),
    .o_valid     (rx_valid),
    .o_frame_err (rx_ferr)
  );

  // Length arrives LSB first, so each byte shifts in from the top
  assign len_full  = {byte_buf, len_sr[31:8]};
  assign len_n     = len_sr[W-1:0];
  assign last_byte = (byte_cnt + W'(1)) == len_n;

  // Next state and byte-consume decision; line errors and overrun win over everything before DONE
  always_comb begin
    state_nxt = state;
    consume   = 1'b0;
    case (state)
      ST_LEN: begin
        if (byte_pend) begin
          consume = 1'b1;
          if (len_idx == 2'd3) begin
            if (len_full > MEM_LIM)     state_nxt = ST_ERROR;
            else if (len_full == 32'd0) state_nxt = ST_TAIL;
            else                        state_nxt = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (byte_pend) begin
          consume = 1'b1;
          if (byte_cnt[1:0] == 2'd3 || last_byte) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (o_wb_dbg_stb && i_wb_dbg_ack)
          state_nxt = (byte_cnt == len_n) ? ST_TAIL : ST_DATA;
      end
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
      ST_CKSUM: begin
        if (byte_pend) begin
          consume   = 1'b1;
          state_nxt = (byte_buf == sum) ? ST_DONE : ST_ERROR;
        end
      end
`endif
      default: state_nxt = state;
    endcase
    if (state != ST_DONE && state != ST_ERROR &&
        (rx_ferr || (rx_valid && byte_pend && !consume)))
      state_nxt = ST_ERROR;
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_LEN;
    else          state <= state_nxt;
  end

  // Byte buffer, length/payload counters, word packer and write strobe
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      byte_buf     <= 8'd0;
      byte_pend    <= 1'b0;
      len_sr       <= 32'd0;
      len_idx      <= 2'd0;
      byte_cnt     <= '0;
      word_idx     <= '0;
      o_wb_dbg_dat <= 32'd0;
      o_wb_dbg_stb <= 1'b0;
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
      sum          <= 8'd0;
`endif
    end else begin
      byte_pend <= (byte_pend && !consume) || rx_valid;
      if (rx_valid) byte_buf <= rx_data;
      if (state == ST_LEN && consume) begin
        len_sr  <= len_full;
        len_idx <= len_idx + 2'd1;
      end
      if (state == ST_DATA && consume) begin
        // First byte of a word clears the rest so a short final word is zero-padded
        if (byte_cnt[1:0] == 2'd0) o_wb_dbg_dat <= {24'd0, byte_buf};
        else                       o_wb_dbg_dat[{byte_cnt[1:0], 3'b000} +: 8] <= byte_buf;
        byte_cnt <= byte_cnt + W'(1);
`ifdef SUBSERVIENT_LOADER_CHECKSUM_EN
        sum      <= sum + byte_buf;
`endif
      end
      // Strobe rises the cycle after entering WRITE and falls the cycle after ack
      o_wb_dbg_stb <= (state == ST_WRITE) && (state_nxt == ST_WRITE);
      if (state == ST_WRITE && o_wb_dbg_stb && i_wb_dbg_ack) word_idx <= word_idx + W'(1);
    end
  end

  assign o_wb_dbg_adr = {{(30 - W){1'b0}}, word_idx, 2'b00};
  assign o_wb_dbg_sel = WB_SEL_ALL;
  assign o_wb_dbg_we  = 1'b1;
  assign o_debug_mode = (state != ST_DONE);
  assign o_done       = (state == ST_DONE);
  assign o_error      = (state == ST_ERROR);

endmodule
